complex_dot_scheduler: RTL
==========================

# complex_dot_scheduler

Sequencer for the complex dot-product engine that computes a full ROWS x COLS complex matrix product one output element at a time. Per element it issues a (row, col) operand-select to the engine's input handshake. It keeps an in-order tag FIFO of issued coordinates and, as results return, steers each one to the writeback port tagged with its row/col. It sits between the job-control register interface and the dot-product engine plus operand storage, and bounds the number of elements in flight.

## Interface
- ROWS, 4: output matrix rows; power of two, >= 2.
- COLS, 4: output matrix columns; power of two, >= 2.
- MAX_INFLIGHT, 8: tag FIFO depth and in-flight limit; power of two, >= 2.
- clk_i  in  1  clock; all logic is rising-edge.
- rst_ni  in  1  reset, synchronous, active-low.
- start_i  in  1  begin a job; sampled only in IDLE, ignored otherwise.
- flush_i  in  1  abort job; synchronous, takes priority over everything except reset.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse when the last element has been written back.
- err_o  out  1  sticky; set when a result arrives with the tag FIFO empty; cleared by reset or start.
- issue_valid_o  out  1  to engine in_valid_i.
- issue_ready_i  in  1  from engine in_ready_o.
- issue_row_o  out  $clog2(ROWS)  A-row select for the operand mux.
- issue_col_o  out  $clog2(COLS)  B-column select for the operand mux.
- result_valid_i  in  1  from engine out_valid_o.
- result_ready_o  out  1  to engine out_ready_i.
- wr_valid_o  out  1  writeback request; result data travels alongside, outside this block.
- wr_ready_i  in  1  writeback sink ready.
- wr_row_o  out  $clog2(ROWS)  tag of the result being written.
- wr_col_o  out  $clog2(COLS)  tag of the result being written.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE -> ISSUE: on start_i. This clears the coordinate counters, the in-flight count and err_o.
- ISSUE -> DRAIN: on the issue handshake of coordinate (ROWS-1, COLS-1).
- DRAIN -> IDLE: on the writeback handshake that brings the in-flight count to 0. The done_o pulse registers in the same edge.
- Any state -> IDLE on flush_i. Flush clears the counters and the FIFO, does not pulse done_o, and leaves err_o unchanged.
- Issue order is row-major: col increments first, and row increments when col wraps from COLS-1 to 0.
- issue_valid_o = (state==ISSUE) && (inflight < MAX_INFLIGHT).
- While issue_valid_o is high and issue_ready_i is low, issue_row_o/issue_col_o are stable.
- The issue handshake pushes {row,col} into the tag FIFO, increments inflight and advances the coordinates.
- Result path is combinational:
  - wr_valid_o = result_valid_i && !fifo_empty.
  - result_ready_o = wr_ready_i && !fifo_empty.
  - wr_row_o/wr_col_o = FIFO head.
- The writeback handshake (result_valid_i && result_ready_o) pops the FIFO and decrements inflight.
- Issue and writeback in the same cycle: inflight unchanged; FIFO push and pop both occur.
- result_valid_i with an empty FIFO sets err_o. result_ready_o stays 0 and the result is not consumed.
- inflight has width $clog2(MAX_INFLIGHT)+1. It never exceeds MAX_INFLIGHT and never underflows.
- The FIFO is a circular buffer with wrapping read/write pointers; its full flag is equivalent to inflight == MAX_INFLIGHT.

## Timing
- Reset: every output is 0, state is IDLE, FIFO is empty, inflight is 0.
- start_i sampled at edge N gives busy_o=1 and issue_valid_o=1 from cycle N+1.
- With ready held high: one issue per cycle, and results are consumed in the cycle they become valid (zero added latency on the result path).
- done_o rises the cycle after the final writeback handshake and lasts exactly one cycle. busy_o falls in that same cycle.
- Back-to-back jobs: start_i in the cycle done_o is high is accepted.
- A flush in the same cycle as a handshake wins; the handshake's FIFO/counter effects are discarded.
- Minimum job length with ideal engine latency L: ROWS*COLS + L + 1 cycles from start to done_o.

## Test plan
- Defaults, engine latency 3, all readies high:
  - 16 issues occur in consecutive cycles in order (0,0),(0,1)...(3,3).
  - 16 writebacks occur with matching tags.
  - done_o is high exactly once, 20 cycles after start.
- Engine latency 20, MAX_INFLIGHT=8:
  - issue_valid_o drops after 8 issues and inflight holds at 8.
  - The next issue occurs in the cycle after the first writeback.
  - No tag mismatch.
- wr_ready_i toggled randomly at 50%:
  - result_ready_o equals wr_ready_i whenever the FIFO is non-empty.
  - Tags remain in order and all 16 elements are written.
- flush_i asserted after issue 5 with 3 results in flight:
  - Next cycle: busy_o=0, issue_valid_o=0, result_ready_o=0.
  - No done_o.
  - A new start then reissues from (0,0) with the FIFO empty.
- Spurious result_valid_i in IDLE: err_o=1 next cycle and result_ready_o=0. A subsequent start clears err_o.
- rst_ni low mid-job (inflight=4) for one cycle: all outputs 0 the next cycle, and state is IDLE.

Source files
------------

// File: rtl/complex_dot_scheduler.sv
// rtl/complex_dot_scheduler.sv - row-major issue sequencer with in-order tag FIFO for the complex dot engine
module complex_dot_scheduler #(
   parameter int ROWS         = 4,
   parameter int COLS         = 4,
   parameter int MAX_INFLIGHT = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      start_i,
   input  logic                      flush_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      err_o,
   output logic                      issue_valid_o,
   input  logic                      issue_ready_i,
   output logic [$clog2(ROWS)-1:0]   issue_row_o,
   output logic [$clog2(COLS)-1:0]   issue_col_o,
   input  logic                      result_valid_i,
   output logic                      result_ready_o,
   output logic                      wr_valid_o,
   input  logic                      wr_ready_i,
   output logic [$clog2(ROWS)-1:0]   wr_row_o,
   output logic [$clog2(COLS)-1:0]   wr_col_o
);
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int PW = $clog2(MAX_INFLIGHT);
   localparam int IW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t            r_state;
   logic [RW-1:0]     r_row;
   logic [CW-1:0]     r_col;
   logic [IW-1:0]     r_inflight;
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [RW+CW-1:0]  r_tags [MAX_INFLIGHT];
   logic              r_done;
   logic              r_err;

   logic              w_empty;
   logic              w_issue_hs;
   logic              w_wb_hs;
   logic              w_last_coord;

   assign w_empty        = (r_inflight == '0);
   assign issue_valid_o  = (r_state == S_ISSUE) && (r_inflight < IW'(MAX_INFLIGHT));
   assign w_issue_hs     = issue_valid_o && issue_ready_i;
   assign result_ready_o = wr_ready_i && !w_empty;
   assign wr_valid_o     = result_valid_i && !w_empty;
   assign w_wb_hs        = result_valid_i && result_ready_o;
   assign w_last_coord   = &{r_row, r_col};

   // Head is gated so the tag outputs read 0 whenever nothing is in flight.
   assign {wr_row_o, wr_col_o} = w_empty ? '0 : r_tags[r_rptr];

   assign issue_row_o = r_row;
   assign issue_col_o = r_col;
   assign busy_o      = (r_state != S_IDLE);
   assign done_o      = r_done;
   assign err_o       = r_err;

   always_ff @(posedge clk_i) begin
      if (w_issue_hs) begin
         r_tags[r_wptr] <= {r_row, r_col};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_row      <= '0;
         r_col      <= '0;
         r_inflight <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (flush_i) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_inflight <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
         end else begin
            if (result_valid_i && w_empty) begin
               r_err <= 1'b1;
            end
            // Power-of-two dims let the concatenated coordinate wrap row-major for free.
            if (w_issue_hs) begin
               {r_row, r_col} <= {r_row, r_col} + 1'b1;
               r_wptr         <= r_wptr + 1'b1;
            end
            if (w_wb_hs) begin
               r_rptr <= r_rptr + 1'b1;
            end
            case ({w_issue_hs, w_wb_hs})
               2'b10:   r_inflight <= r_inflight + 1'b1;
               2'b01:   r_inflight <= r_inflight - 1'b1;
               default: r_inflight <= r_inflight;
            endcase
            case (r_state)
               S_IDLE: begin
                  if (start_i) begin
                     r_state    <= S_ISSUE;
                     r_row      <= '0;
                     r_col      <= '0;
                     r_inflight <= '0;
                     r_wptr     <= '0;
                     r_rptr     <= '0;
                     r_err      <= 1'b0;
                  end
               end
               S_ISSUE: begin
                  if (w_issue_hs && w_last_coord) begin
                     r_state <= S_DRAIN;
                  end
               end
               S_DRAIN: begin
                  if (w_wb_hs && (r_inflight == IW'(1))) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end
endmodule
